// File: rtl/grass_bg_wind.sv
// ---------------------------------------------------------------------------
// grass_bg_wind
//   Animated grass background for the VGA pixel pipeline. A band of blades
//   between HORIZON_Y and BASE_Y sits above a solid grass base. The scene
//   scrolls horizontally one pixel every SCROLL_DIV frames. A wind FSM
//   (CALM/RISE/HOLD/FALL) bends the blade tips by up to SWAY_MAX pixels in a
//   direction picked by an 8-bit LFSR when each gust starts.
//
//   Optional feature macro: GRASS_FLOWERS_EN
//     When defined, one row of yellow flowers (every 64 px) appears in the
//     grass base and scrolls with the grass.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous reset, active-high
//   frame_start  in   one-cycle pulse per frame; animation state advances only here
//   display_on   in   visible-area qualifier (colour forced to 0 when low)
//   wind_en      in   1 = gusts allowed, 0 = wind dies down
//   pix_x        in   [9:0] pixel column
//   pix_y        in   [9:0] pixel row
//   r, g, b      out  [1:0] registered colour, one cycle after pix_x/pix_y
//   gust         out  high while the wind FSM is in RISE, HOLD or FALL
// ---------------------------------------------------------------------------
module grass_bg_wind #(
    parameter int          HORIZON_Y   = 224,
    parameter int          BASE_Y      = 240,
    parameter int          PITCH_LOG2  = 4,
    parameter int          SWAY_MAX    = 3,
    parameter int          SCROLL_DIV  = 4,
    parameter int          CALM_FRAMES = 60,
    parameter int          HOLD_FRAMES = 30,
    parameter logic [5:0]  SKY_RGB     = 6'b001011,
    parameter logic [5:0]  GRASS_RGB   = 6'b001100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       display_on,
    input  logic       wind_en,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       gust
);

    localparam int PL = PITCH_LOG2;
    localparam int TW = 16;
    localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [9:0]    HORIZON_C   = 10'(HORIZON_Y);
    localparam logic [9:0]    BASE_C      = 10'(BASE_Y);
    localparam logic [9:0]    SHORT_Y_C   = 10'(HORIZON_Y + 8);
    localparam logic [9:0]    MID_Y_C     = 10'((HORIZON_Y + BASE_Y) / 2);
    localparam logic [PL-1:0] SWAY_MAX_C  = PL'(SWAY_MAX);
    localparam logic [PL-1:0] HIT_LO_C    = PL'((2 ** PL) / 2 - 1);
    localparam logic [PL-1:0] HIT_HI_C    = PL'((2 ** PL) / 2);
    localparam logic [TW-1:0] CALM_LAST_C = TW'(CALM_FRAMES - 1);
    localparam logic [TW-1:0] HOLD_LAST_C = TW'(HOLD_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST_C  = DW'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        CALM = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } wind_state_t;

    wind_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PL-1:0] sway_q,  sway_d;
    logic          dir_q,   dir_d;
    logic [7:0]    lfsr_q,  lfsr_d;
    logic [DW-1:0] div_q,   div_d;
    logic [9:0]    scroll_q, scroll_d;
    logic [5:0]    rgb_q,   rgb_d;

    // ------------------------------------------------------------------
    // Animation state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CALM;
            timer_q  <= '0;
            sway_q   <= '0;
            dir_q    <= 1'b0;
            lfsr_q   <= 8'hA5;
            div_q    <= '0;
            scroll_q <= '0;
            rgb_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sway_q   <= sway_d;
            dir_q    <= dir_d;
            lfsr_q   <= lfsr_d;
            div_q    <= div_d;
            scroll_q <= scroll_d;
            rgb_q    <= rgb_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-frame next state: LFSR, scroll divider and wind FSM
    // ------------------------------------------------------------------
    logic [PL-1:0] sway_inc;
    assign sway_inc = sway_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        sway_d   = sway_q;
        dir_d    = dir_q;
        lfsr_d   = lfsr_q;
        div_d    = div_q;
        scroll_d = scroll_q;

        if (frame_start) begin
            // Fibonacci taps 8,6,5,4 (bits 7,5,4,3); maximal length, never 0
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

            if (div_q == DIV_LAST_C) begin
                div_d    = '0;
                scroll_d = scroll_q + 10'd1;
            end else begin
                div_d = div_q + 1'b1;
            end

            unique case (state_q)
                CALM: begin
                    // Timer parks at its last value until wind is allowed
                    if (timer_q == CALM_LAST_C) begin
                        if (wind_en) begin
                            state_d = RISE;
                            timer_d = '0;
                            dir_d   = lfsr_q[0];
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                RISE: begin
                    if (!wind_en) begin
                        state_d = FALL;
                        timer_d = '0;
                    end else if (sway_q >= SWAY_MAX_C || sway_inc >= SWAY_MAX_C) begin
                        // Covers SWAY_MAX=0: go straight to HOLD with no sway
                        sway_d  = SWAY_MAX_C;
                        state_d = HOLD;
                        timer_d = '0;
                    end else begin
                        sway_d = sway_inc;
                    end
                end
                HOLD: begin
                    if (!wind_en || timer_q == HOLD_LAST_C) begin
                        state_d = FALL;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                FALL: begin
                    // Return to CALM on the frame where sway reaches 0
                    if (sway_q <= PL'(1)) begin
                        sway_d  = '0;
                        state_d = CALM;
                        timer_d = '0;
                    end else begin
                        sway_d = sway_q - 1'b1;
                    end
                end
                default: state_d = CALM;
            endcase
        end
    end

    assign gust = (state_q != CALM);

    // ------------------------------------------------------------------
    // Pixel colour (uses pre-update animation state)
    // ------------------------------------------------------------------
    logic [9:0]    xs;
    logic [PL-1:0] xl;
    logic [PL-1:0] off;
    logic [PL-1:0] blade_pos;
    logic          in_band;
    logic          in_base;
    logic          blade_hit;
    logic          unused_xs;

    assign xs  = pix_x + scroll_q;
    assign xl  = xs[PL-1:0];
    // Lower half of the blade band bends half as much as the tips
    assign off = (pix_y < MID_Y_C) ? sway_q : (sway_q >> 1);
    // (xl - lean) mod P, lean = +off when dir=1, -off when dir=0
    assign blade_pos = dir_q ? (xl - off) : (xl + off);

    assign in_band = (pix_y >= HORIZON_C) && (pix_y < BASE_C);
    assign in_base = (pix_y >= BASE_C);
    // Odd-numbered blades (xs[PL]=1) are short and start 8 rows lower
    assign blade_hit = in_band
                     && ((blade_pos == HIT_LO_C) || (blade_pos == HIT_HI_C))
                     && (!xs[PL] || (pix_y >= SHORT_Y_C));

    assign unused_xs = ^xs;

    always_comb begin
        rgb_d = SKY_RGB;
        if (!display_on) begin
            rgb_d = 6'b000000;
        end else if (in_base) begin
            rgb_d = GRASS_RGB;
`ifdef GRASS_FLOWERS_EN
            if (xs[5:0] == 6'd9 && pix_y == (BASE_C + 10'd3)) begin
                rgb_d = 6'b111100;
            end
`endif
        end else if (blade_hit) begin
            rgb_d = GRASS_RGB;
        end
    end

    assign r = rgb_q[5:4];
    assign g = rgb_q[3:2];
    assign b = rgb_q[1:0];

endmodule
